// File: rtl/stopwatch_core.sv
// ---------------------------------------------------------------------------
// stopwatch_core
//   Time base and BCD counting engine for the stopwatch. Two raw push-buttons
//   are synchronised, debounced and edge-detected into start/stop and clear
//   events that drive an IDLE/RUN/PAUSE state machine. In RUN a prescaler
//   divides the clock down to centisecond ticks, and each tick advances the
//   packed BCD time word MM:SS.cc.
//
// Parameters
//   CLK_HZ          input clock frequency
//   TICK_HZ         count rate; DIV = CLK_HZ/TICK_HZ must be an integer >= 2
//   DEBOUNCE_CYCLES consecutive stable cycles needed to accept a key change
//
// Ports
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   key_start_n  in   raw start/stop key, asynchronous, low = pressed
//   key_clear_n  in   raw clear key, asynchronous, low = pressed
//   data[23:0]   out  BCD time {min tens, min units, sec tens, sec units,
//                     cs tens, cs units}, registered
//   running      out  high while in RUN, registered
//   tick         out  one-cycle pulse on every count increment, registered
// ---------------------------------------------------------------------------
module stopwatch_core #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int TICK_HZ         = 100,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_start_n,
    input  logic        key_clear_n,
    output logic [23:0] data,
    output logic        running,
    output logic        tick
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Increment a packed BCD time word by one centisecond. Digits at or above
    // their limit roll to zero and carry, so a corrupted digit self-heals
    // instead of ever counting into a non-BCD code.
    function automatic logic [23:0] bcd_inc(input logic [23:0] t);
        logic [23:0] r;
        logic        carry;
        logic [3:0]  lim;
        r     = t;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lim = ((i == 3) || (i == 5)) ? 4'd5 : 4'd9;
            if (carry) begin
                if (r[i*4 +: 4] >= lim) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Key path: index 0 = start/stop, index 1 = clear
    // ------------------------------------------------------------------
    logic [1:0] key_raw_s;
    logic [1:0] press_s;

    assign key_raw_s = {key_clear_n, key_start_n};

    for (genvar gi = 0; gi < 2; gi++) begin : g_key
        logic          sync1_r;
        logic          sync2_r;
        logic          deb_r;
        logic          deb_d_r;
        logic [DW-1:0] cnt_r;

        // Synchroniser, debounce counter and debounced-level history.
        // Reset parks everything at "released" so no event follows reset.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sync1_r <= 1'b1;
                sync2_r <= 1'b1;
                deb_r   <= 1'b1;
                deb_d_r <= 1'b1;
                cnt_r   <= '0;
            end else begin
                sync1_r <= key_raw_s[gi];
                sync2_r <= sync1_r;
                deb_d_r <= deb_r;
                if (sync2_r != deb_r) begin
                    // The level must differ on DEBOUNCE_CYCLES consecutive
                    // samples; the last of them flips the debounced level.
                    if (cnt_r == DEB_LAST) begin
                        deb_r <= sync2_r;
                        cnt_r <= '0;
                    end else begin
                        cnt_r <= cnt_r + DW'(1);
                    end
                end else begin
                    cnt_r <= '0;
                end
            end
        end

        // Press = debounced 1->0; release produces nothing.
        assign press_s[gi] = deb_d_r & ~deb_r;
    end

    logic start_ev_s;
    logic clear_ev_s;

    assign start_ev_s = press_s[0];
    assign clear_ev_s = press_s[1];

    // ------------------------------------------------------------------
    // Control state, prescaler and time word
    // ------------------------------------------------------------------
    state_t        state_r;
    state_t        state_s;
    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_s;
    logic [23:0]   time_r;
    logic [23:0]   time_s;
    logic          running_r;
    logic          tick_r;
    logic          tick_s;

    // Next-state logic. In PAUSE clear beats start; elsewhere clear is ignored.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ev_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (start_ev_s) begin
                    state_s = ST_PAUSE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (clear_ev_s) begin
                    state_s = ST_IDLE;
                end else if (start_ev_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_PAUSE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath next values. The prescaler and time word follow the current
    // state, so the edge that leaves RUN still counts and may still tick.
    always_comb begin
        presc_s = presc_r;
        time_s  = time_r;
        tick_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                presc_s = '0;
                time_s  = 24'h00_0000;
            end
            ST_RUN: begin
                if (presc_r == PRESC_LAST) begin
                    presc_s = '0;
                    tick_s  = 1'b1;
                    time_s  = bcd_inc(time_r);
                end else begin
                    presc_s = presc_r + PW'(1);
                end
            end
            ST_PAUSE: begin
                if (clear_ev_s) begin
                    presc_s = '0;
                    time_s  = 24'h00_0000;
                end else begin
                    presc_s = presc_r;
                    time_s  = time_r;
                end
            end
            default: begin
                presc_s = '0;
                time_s  = 24'h00_0000;
            end
        endcase
    end

    // State, datapath and output registers. running is derived from the next
    // state so it changes on the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            presc_r   <= '0;
            time_r    <= 24'h00_0000;
            running_r <= 1'b0;
            tick_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            presc_r   <= presc_s;
            time_r    <= time_s;
            running_r <= (state_s == ST_RUN);
            tick_r    <= tick_s;
        end
    end

    assign data    = time_r;
    assign running = running_r;
    assign tick    = tick_r;

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Time-base and BCD counting engine for the stopwatch. It turns two raw push-button inputs into start/stop/clear control and produces the packed 24-bit BCD time word (MM:SS.cc) that drives the six-digit seven-segment display stage. It sits between the board keys and the display decoder, and is the only writer of the displayed time.

## Interface

Parameters:
- CLK_HZ, 50_000_000 — input clock frequency.
- TICK_HZ, 100 — count rate (one centisecond per tick). DIV = CLK_HZ/TICK_HZ must be an integer ≥ 2.
- DEBOUNCE_CYCLES, 500_000 — consecutive stable cycles required to accept a key level change (≥ 1).

Ports:
- clk  in  1  — system clock.
- rst_n  in  1  — reset, synchronous, active-low.
- key_start_n  in  1  — raw start/stop key, asynchronous, low = pressed.
- key_clear_n  in  1  — raw clear key, asynchronous, low = pressed.
- data  out  24  — packed BCD time:
  - [3:0] centiseconds units
  - [7:4] centiseconds tens
  - [11:8] seconds units
  - [15:12] seconds tens (0–5)
  - [19:16] minutes units
  - [23:20] minutes tens (0–5)
- running  out  1  — high while in RUN.
- tick  out  1  — one-cycle pulse on each count increment.

## Operation

- Key path, per key:
  - 2-FF synchroniser.
  - Debouncer: debounced level takes the synchronised value after it has differed from the current debounced level for DEBOUNCE_CYCLES consecutive cycles. Any bounce back restarts the count.
  - Press event: one-cycle pulse when the debounced level goes 1→0. Release generates no event.
- State machine, states IDLE, RUN, PAUSE:
  - IDLE: data = 0, prescaler = 0. start event → RUN. clear event → stays IDLE.
  - RUN: prescaler counts. start event → PAUSE. clear event is ignored.
  - PAUSE: data and prescaler hold. start event → RUN, resuming from the held prescaler value. clear event → IDLE, zeroing data and prescaler.
  - Start and clear events in the same cycle: in PAUSE, clear wins (→ IDLE, start discarded). In IDLE or RUN, only the start event applies.
- Prescaler:
  - 0..DIV-1, advances only in RUN.
  - When it equals DIV-1 in RUN, it wraps to 0, tick pulses, and data increments by one centisecond on that same edge.
- BCD arithmetic:
  - Each digit rolls to 0 and carries at its limit: 9 for units; 9 for cs tens; 5 for sec tens; 9 for min units; 5 for min tens.
  - 59:59.99 + 1 → 00:00.00 (full wrap). The block stays in RUN and no flag is raised.
  - No digit ever holds a non-BCD value.
- Reset:
  - rst_n low at any clock edge gives: state IDLE, data 0, prescaler 0, running 0, tick 0.
  - Debounced levels = 1 (released), debounce counters = 0, synchroniser flops = 1.
  - Reset mid-count discards the time; no press event is generated on reset release.

## Timing

- Key latency: from the raw key edge to the press event is 2 sync cycles + DEBOUNCE_CYCLES + 1 edge-detect cycle.
- State changes on the edge after the event pulse. running is registered and reflects the new state in that same cycle.
- First tick after IDLE→RUN: DIV cycles after running rises. data = 00:00.01 in the same cycle tick is high.
- After PAUSE→RUN, the next tick comes after DIV minus the held prescaler value.
- data, running and tick are all registered outputs, with no combinational path from the inputs.
- Steady-state tick period is exactly DIV cycles.

## Test plan

All cases use CLK_HZ=1000, TICK_HZ=100 (DIV=10) and DEBOUNCE_CYCLES=4.

- Reset: hold rst_n=0 for 3 cycles with both keys pressed, then release rst_n.
  - data=0x000000, running=0, tick=0.
  - No state change until a fresh 1→0 debounced transition.
- Start and count: press key_start_n.
  - running rises 7 cycles after the key edge.
  - tick every 10 cycles; after 100 ticks data=0x000100 (00:01.00).
- Bounce rejection: key_start_n pulses low for 3 cycles, high 1 cycle, low 3 cycles.
  - No event, running stays 0.
  - A subsequent stable low of ≥ 4 cycles gives exactly one event.
- Pause and clear:
  - Stop at 00:00.37 with prescaler at 6 → data holds 0x000037 indefinitely.
  - Start again → next tick after 4 cycles, data=0x000038.
  - Stop, then clear → data=0x000000, state IDLE.
  - Clear pressed while running has no effect.
- Carry and wrap:
  - Preload via force/count to 00:59.99, one tick → 0x010000.
  - From 59:59.99, one tick → 0x000000; running stays 1.
- Simultaneous events: in PAUSE, assert start and clear press events in the same cycle → IDLE, data=0, running=0.
